// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between duck (0), dog (1) and score (2).
// Grants issue one registered ROM read per cycle; a tag pipeline steers each returned word back to its requester.
module sprite_rom_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        ack,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [2:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [1:0]        ptr;
    logic [1:0]        win;
    logic [1:0]        cand;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;

    logic [ROM_LAT:0]  tag_vld_p;
    logic [1:0]        tag_id_p [0:ROM_LAT];

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

    // Search ptr, ptr+1, ptr+2 (mod 3); the first active request wins.
    always_comb begin
        grant = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!grant && req[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
            cand = inc3(cand);
        end
    end

    always_comb begin
        ack = (grant && Reset_n) ? onehot3(win) : 3'b000;
        case (win)
            2'd0:    win_addr = addr0;
            2'd1:    win_addr = addr1;
            default: win_addr = addr2;
        endcase
    end

    // Issue stage and tag pipeline; the tail stage lines up with rom_data.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr       <= 2'd0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            tag_vld_p <= '0;
            for (int s = 0; s <= ROM_LAT; s++) tag_id_p[s] <= 2'd0;
            rd_valid  <= 3'b000;
            rd_data   <= '0;
        end else begin
            rom_rd <= |ack;
            if (|ack) begin
                rom_addr <= win_addr;
                ptr      <= inc3(win);
            end

            tag_vld_p[0] <= |ack;
            tag_id_p[0]  <= win;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
                tag_id_p[s]  <= tag_id_p[s-1];
            end

            if (tag_vld_p[ROM_LAT]) begin
                rd_valid <= onehot3(tag_id_p[ROM_LAT]);
                rd_data  <= rom_data;
            end else begin
                rd_valid <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a ROM_LAT=1 instance and a ROM_LAT=4 instance,
// each fed by a model ROM that returns addr[7:0].
module tb_sprite_rom_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          Reset_n;
    logic [2:0]    req;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [2:0]    ack;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [2:0]    rd_valid;
    logic [DW-1:0] rd_data;

    logic [2:0]    req4;
    logic [AW-1:0] b0, b1, b2;
    logic [2:0]    ack4;
    logic          rom_rd4;
    logic [AW-1:0] rom_addr4;
    logic [DW-1:0] rom_data4;
    logic [2:0]    rd_valid4;
    logic [DW-1:0] rd_data4;

    int checks = 0;
    int errors = 0;

    sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .ack(ack), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req4),
        .addr0(b0), .addr1(b1), .addr2(b2),
        .ack(ack4), .rom_rd(rom_rd4), .rom_addr(rom_addr4), .rom_data(rom_data4),
        .rd_valid(rd_valid4), .rd_data(rd_data4)
    );

    // Model ROMs: word = low byte of the sampled address, ROM_LAT cycles later.
    logic [DW-1:0] rq1;
    logic [DW-1:0] rq4 [0:3];
    always_ff @(posedge Clk) begin
        rq1    <= rom_addr[7:0];
        rq4[0] <= rom_addr4[7:0];
        rq4[1] <= rq4[0];
        rq4[2] <= rq4[1];
        rq4[3] <= rq4[2];
    end
    assign rom_data  = rq1;
    assign rom_data4 = rq4[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic [2:0] r,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge Clk);
        Reset_n = rn;
        req     = r;
        addr0   = a0;
        addr1   = a1;
        addr2   = a2;
        #1;
    endtask

    task automatic step4(input logic [2:0] r, input logic [AW-1:0] a1);
        @(negedge Clk);
        Reset_n = 1'b1;
        req     = 3'b000;
        req4    = r;
        b1      = a1;
        #1;
    endtask

    logic [2:0] e_ack, e_vld;
    logic [7:0] e_dat;

    initial begin
        Reset_n = 1'b0;
        req = 3'b000; addr0 = '0; addr1 = '0; addr2 = '0;
        req4 = 3'b000; b0 = '0; b1 = '0; b2 = '0;

        // Reset with requests pending: no ack, and no rom_rd afterwards
        step(1'b0, 3'b111, 16'h0011, 16'h0022, 16'h0033);
        chk("rst_ack", ack, 3'b000);
        chk("rst_ack4", ack4, 3'b000);
        step(1'b0, 3'b000, 0, 0, 0);
        chk("rst_rom_rd", rom_rd, 1'b0);
        chk("rst_rom_addr", rom_addr, 16'h0000);
        chk("rst_rd_valid", rd_valid, 3'b000);
        chk("rst_rd_data", rd_data, 8'h00);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'b000, 0, 0, 0);
            chk("idle_ack", ack, 3'b000);
            chk("idle_rom_rd", rom_rd, 1'b0);
            chk("idle_rom_addr", rom_addr, 16'h0000);
            chk("idle_rd_valid", rd_valid, 3'b000);
            chk("idle_rd_data", rd_data, 8'h00);
        end

        // Single read by dog
        step(1'b1, 3'b010, 0, 16'h0123, 0);
        chk("single_ack", ack, 3'b010);
        step(1'b1, 3'b000, 0, 16'h0123, 0);
        chk("single_ack_off", ack, 3'b000);
        chk("single_rom_rd", rom_rd, 1'b1);
        chk("single_rom_addr", rom_addr, 16'h0123);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("single_early", rd_valid, 3'b000);
        chk("single_rom_rd_off", rom_rd, 1'b0);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("single_rd_valid", rd_valid, 3'b010);
        chk("single_rd_data", rd_data, 8'h23);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("single_pulse_end", rd_valid, 3'b000);
        chk("single_data_hold", rd_data, 8'h23);

        // ptr=2 now: a lone score request moves it back to 0
        step(1'b1, 3'b100, 0, 0, 16'h0030);
        chk("score_ack", ack, 3'b100);
        step(1'b1, 3'b000, 0, 0, 0);
        step(1'b1, 3'b000, 0, 0, 0);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("score_rd_valid", rd_valid, 3'b100);
        chk("score_rd_data", rd_data, 8'h30);

        // All three held for 9 cycles, then drain
        for (int i = 0; i < 13; i++) begin
            step(1'b1, (i < 9) ? 3'b111 : 3'b000, 16'h0010, 16'h0020, 16'h0030);
            e_ack = (i < 9) ? (3'b001 << (i % 3)) : 3'b000;
            chk("rr_ack", ack, e_ack);
            chk("rr_rom_rd", rom_rd, (i >= 1 && i <= 9) ? 1'b1 : 1'b0);
            if (i >= 1 && i <= 9)
                chk("rr_rom_addr", rom_addr, 16'h0010 * ((i - 1) % 3 + 1));
            if (i >= 3 && i <= 11) begin
                e_vld = 3'b001 << ((i - 3) % 3);
                e_dat = 8'h10 * ((i - 3) % 3 + 1);
                chk("rr_rd_valid", rd_valid, e_vld);
                chk("rr_rd_data", rd_data, e_dat);
            end else begin
                chk("rr_rd_valid_idle", rd_valid, 3'b000);
            end
        end

        // Last grant went to 2: with req=011 held, 0 then 1
        step(1'b1, 3'b011, 16'h0010, 16'h0020, 0);
        chk("fair_ack0", ack, 3'b001);
        step(1'b1, 3'b011, 16'h0010, 16'h0020, 0);
        chk("fair_ack1", ack, 3'b010);
        step(1'b1, 3'b000, 0, 0, 0);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("fair_rd_valid0", rd_valid, 3'b001);
        chk("fair_rd_data0", rd_data, 8'h10);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("fair_rd_valid1", rd_valid, 3'b010);
        chk("fair_rd_data1", rd_data, 8'h20);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("fair_drained", rd_valid, 3'b000);

        // Reset mid-flight: the in-flight read never returns
        step(1'b1, 3'b001, 16'h0077, 0, 0);
        chk("mid_ack", ack, 3'b001);
        step(1'b0, 3'b000, 0, 0, 0);
        chk("mid_ack_rst", ack, 3'b000);
        chk("mid_rom_rd", rom_rd, 1'b1);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("mid_rom_rd_clr", rom_rd, 1'b0);
        chk("mid_rom_addr_clr", rom_addr, 16'h0000);
        chk("mid_rd_data_clr", rd_data, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b000, 0, 0, 0);
            chk("mid_no_return", rd_valid, 3'b000);
        end
        step(1'b1, 3'b011, 16'h0044, 16'h0055, 0);
        chk("mid_ptr0_ack", ack, 3'b001);
        step(1'b1, 3'b000, 0, 0, 0);
        step(1'b1, 3'b000, 0, 0, 0);
        step(1'b1, 3'b000, 0, 0, 0);
        chk("mid_after_valid", rd_valid, 3'b001);
        chk("mid_after_data", rd_data, 8'h44);

        // ROM_LAT=4 instance: 5 back-to-back dog reads
        for (int i = 0; i < 13; i++) begin
            step4((i < 5) ? 3'b010 : 3'b000, 16'h0101 + 16'(i));
            chk("lat4_ack", ack4, (i < 5) ? 3'b010 : 3'b000);
            if (i >= 6 && i <= 10) begin
                e_dat = 8'h01 + 8'(i - 6);
                chk("lat4_rd_valid", rd_valid4, 3'b010);
                chk("lat4_rd_data", rd_data4, e_dat);
            end else begin
                chk("lat4_rd_valid_idle", rd_valid4, 3'b000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
